// File: rtl/keypad_lock_ctrl.sv
// Keypad code-lock sequencer: collects four debounced key digits, checks them against CODE,
// and drives progress LEDs, the unlock output, and a timed lockout after repeated wrong entries.
module keypad_lock_ctrl #(
   parameter logic [7:0]  CODE           = 8'b11_10_01_00,
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned OPEN_CYCLES    = 50_000_000,
   parameter int unsigned LOCK_CYCLES    = 250_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 150_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_flag,
   input  logic [1:0] key_code,
   output logic [3:0] ledpin,
   output logic       unlocked,
   output logic       locked_out,
   output logic [1:0] fail_cnt
);

   localparam int unsigned MAX_OL  = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
   localparam int          TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // Timer loads are N-1 so that a state occupies exactly N cycles.
   localparam logic [TW-1:0] OPEN_LOAD    = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LOAD    = TW'(LOCK_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAIL);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_OPEN,
      S_LOCKOUT
   } state_t;

   state_t        r_state,     w_state;
   logic [1:0]    r_digitCnt,  w_digitCnt;
   logic [5:0]    r_digits,    w_digits;
   logic [TW-1:0] r_timer,     w_timer;
   logic [1:0]    r_failCnt,   w_failCnt;
   logic [3:0]    r_led,       w_led;
   logic          r_unlocked,  w_unlocked;
   logic          r_lockedOut, w_lockedOut;
   logic [1:0]    w_failInc;
   logic [7:0]    w_entry;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= S_IDLE;
         r_digitCnt  <= 2'd0;
         r_digits    <= 6'd0;
         r_timer     <= '0;
         r_failCnt   <= 2'd0;
         r_led       <= 4'b1111;
         r_unlocked  <= 1'b0;
         r_lockedOut <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_digitCnt  <= w_digitCnt;
         r_digits    <= w_digits;
         r_timer     <= w_timer;
         r_failCnt   <= w_failCnt;
         r_led       <= w_led;
         r_unlocked  <= w_unlocked;
         r_lockedOut <= w_lockedOut;
      end
   end

   // Digits shift in from the top, so after three keys digit0 sits in r_digits[1:0].
   always_comb begin
      w_state     = r_state;
      w_digitCnt  = r_digitCnt;
      w_digits    = r_digits;
      w_timer     = (r_timer != '0) ? r_timer - 1'b1 : '0;
      w_failCnt   = r_failCnt;
      w_led       = r_led;
      w_unlocked  = r_unlocked;
      w_lockedOut = r_lockedOut;
      w_failInc   = r_failCnt + 2'd1;
      w_entry     = {key_code, r_digits};

      case (r_state)
         S_IDLE: begin
            if (key_flag) begin
               w_digits   = {key_code, r_digits[5:2]};
               w_digitCnt = 2'd1;
               w_timer    = TIMEOUT_LOAD;
               w_led      = 4'b1110;
               w_state    = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (key_flag) begin
               if (r_digitCnt == 2'd3) begin
                  w_digitCnt = 2'd0;
                  if (w_entry == CODE) begin
                     w_state    = S_OPEN;
                     w_timer    = OPEN_LOAD;
                     w_failCnt  = 2'd0;
                     w_led      = 4'b0000;
                     w_unlocked = 1'b1;
                  end else if (w_failInc == FAIL_LIMIT) begin
                     w_state     = S_LOCKOUT;
                     w_timer     = LOCK_LOAD;
                     w_failCnt   = w_failInc;
                     w_led       = 4'b0110;
                     w_lockedOut = 1'b1;
                  end else begin
                     w_state   = S_IDLE;
                     w_timer   = '0;
                     w_failCnt = w_failInc;
                     w_led     = 4'b1111;
                  end
               end else begin
                  w_digits   = {key_code, r_digits[5:2]};
                  w_digitCnt = r_digitCnt + 2'd1;
                  w_timer    = TIMEOUT_LOAD;
                  w_led      = (r_digitCnt == 2'd1) ? 4'b1100 : 4'b1000;
               end
            end else if (r_timer == '0) begin
               w_state    = S_IDLE;
               w_digitCnt = 2'd0;
               w_led      = 4'b1111;
            end
         end
         S_OPEN: begin
            if ((key_flag && key_code == 2'd0) || r_timer == '0) begin
               w_state    = S_IDLE;
               w_timer    = '0;
               w_unlocked = 1'b0;
               w_led      = 4'b1111;
            end
         end
         S_LOCKOUT: begin
            if (r_timer == '0) begin
               w_state     = S_IDLE;
               w_failCnt   = 2'd0;
               w_lockedOut = 1'b0;
               w_led       = 4'b1111;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign ledpin     = r_led;
   assign unlocked   = r_unlocked;
   assign locked_out = r_lockedOut;
   assign fail_cnt   = r_failCnt;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with short timer parameters (OPEN=10, LOCK=20, TIMEOUT=16).
module tb_keypad_lock_ctrl;

   logic       sys_clk    = 1'b0;
   logic       sys_rst_n  = 1'b0;
   logic       key_flag   = 1'b0;
   logic [1:0] key_code   = 2'd0;
   logic [3:0] ledpin;
   logic       unlocked;
   logic       locked_out;
   logic [1:0] fail_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       flag;
      logic [1:0] code;
      logic [3:0] led;
      logic       unl;
      logic       lo;
      logic [1:0] fc;
   } vec_t;

   vec_t vecs[$];

   keypad_lock_ctrl #(
      .CODE           (8'b11_10_01_00),
      .MAX_FAIL       (3),
      .OPEN_CYCLES    (10),
      .LOCK_CYCLES    (20),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_flag   (key_flag),
      .key_code   (key_code),
      .ledpin     (ledpin),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail_cnt   (fail_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Inputs change 1 ns after the edge and hold for one full cycle.
   task automatic applyStimulus(input logic flag, input logic [1:0] code);
      key_flag = flag;
      key_code = code;
      @(posedge sys_clk);
      #1;
      key_flag = 1'b0;
      key_code = 2'd0;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eLed, input logic eUnl,
                              input logic eLo, input logic [1:0] eFc);
      total++;
      if (ledpin !== eLed || unlocked !== eUnl || locked_out !== eLo || fail_cnt !== eFc) begin
         bad++;
         $display("[TB] FAIL %s: got led=%b unl=%b lo=%b fc=%0d, want led=%b unl=%b lo=%b fc=%0d",
                  name, ledpin, unlocked, locked_out, fail_cnt, eLed, eUnl, eLo, eFc);
      end
   endtask

   task automatic stepCheck(input string name, input logic flag, input logic [1:0] code,
                            input logic [3:0] eLed, input logic eUnl, input logic eLo,
                            input logic [1:0] eFc);
      applyStimulus(flag, code);
      checkOutput(name, eLed, eUnl, eLo, eFc);
   endtask

   function automatic void addVec(input logic flag, input logic [1:0] code, input logic [3:0] led,
                                  input logic unl, input logic lo, input logic [1:0] fc);
      vec_t v;
      v.flag = flag;
      v.code = code;
      v.led  = led;
      v.unl  = unl;
      v.lo   = lo;
      v.fc   = fc;
      vecs.push_back(v);
   endfunction

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Three wrong entries 0,1,2,2: fail count climbs, third one enters lockout.
      addVec(1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      addVec(1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd0);
      addVec(1'b1, 2'd2, 4'b1000, 1'b0, 1'b0, 2'd0);
      addVec(1'b1, 2'd2, 4'b1111, 1'b0, 1'b0, 2'd1);
      addVec(1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd1);
      addVec(1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd1);
      addVec(1'b1, 2'd2, 4'b1000, 1'b0, 1'b0, 2'd1);
      addVec(1'b1, 2'd2, 4'b1111, 1'b0, 1'b0, 2'd2);
      addVec(1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd2);
      addVec(1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd2);
      addVec(1'b1, 2'd2, 4'b1000, 1'b0, 1'b0, 2'd2);
      addVec(1'b1, 2'd2, 4'b0110, 1'b0, 1'b1, 2'd3);

      repeat (2) @(posedge sys_clk);
      #1;
      checkOutput("reset", 4'b1111, 1'b0, 1'b0, 2'd0);

      // Correct code, first key lands in the first cycle after reset release.
      sys_rst_n = 1'b1;
      stepCheck("t1_d0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      stepCheck("t1_d1", 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd0);
      stepCheck("t1_d2", 1'b1, 2'd2, 4'b1000, 1'b0, 1'b0, 2'd0);
      stepCheck("t1_d3", 1'b1, 2'd3, 4'b0000, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 9; i++)
         stepCheck($sformatf("t1_open%0d", i), 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd0);
      stepCheck("t1_close", 1'b0, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd0);

      foreach (vecs[i])
         stepCheck($sformatf("vec%0d", i), vecs[i].flag, vecs[i].code,
                   vecs[i].led, vecs[i].unl, vecs[i].lo, vecs[i].fc);
      for (int i = 0; i < 19; i++)
         stepCheck($sformatf("t2_lock%0d", i), (i % 3 == 0), 2'(i),
                   4'b0110, 1'b0, 1'b1, 2'd3);
      stepCheck("t2_expire", 1'b0, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd0);

      // One wrong entry, then a partial entry left to time out.
      stepCheck("t3_w0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      stepCheck("t3_w1", 1'b1, 2'd0, 4'b1100, 1'b0, 1'b0, 2'd0);
      stepCheck("t3_w2", 1'b1, 2'd0, 4'b1000, 1'b0, 1'b0, 2'd0);
      stepCheck("t3_w3", 1'b1, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_p0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_p1", 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd1);
      for (int i = 0; i < 15; i++)
         stepCheck($sformatf("t3_wait%0d", i), 1'b0, 2'd0, 4'b1100, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_timeout", 1'b0, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_c0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_c1", 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_c2", 1'b1, 2'd2, 4'b1000, 1'b0, 1'b0, 2'd1);
      stepCheck("t3_c3", 1'b1, 2'd3, 4'b0000, 1'b1, 1'b0, 2'd0);

      // Relock in OPEN cycle 3; a non-zero key in cycle 2 is ignored.
      stepCheck("t4_cyc1", 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 2'd0);
      stepCheck("t4_key2", 1'b1, 2'd2, 4'b0000, 1'b1, 1'b0, 2'd0);
      stepCheck("t4_relock", 1'b1, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd0);

      // Key arriving in the same cycle the entry timer hits zero.
      stepCheck("t5_d0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      for (int i = 0; i < 15; i++)
         stepCheck($sformatf("t5_wait%0d", i), 1'b0, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      stepCheck("t5_d1_at_expiry", 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd0);
      stepCheck("t5_d2", 1'b1, 2'd2, 4'b1000, 1'b0, 1'b0, 2'd0);
      stepCheck("t5_d3", 1'b1, 2'd3, 4'b0000, 1'b1, 1'b0, 2'd0);
      stepCheck("t5_relock", 1'b1, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd0);

      // Asynchronous reset mid-entry, checked between clock edges.
      stepCheck("t6_e0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      stepCheck("t6_e1", 1'b1, 2'd1, 4'b1100, 1'b0, 1'b0, 2'd0);
      #2;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_entry", 4'b1111, 1'b0, 1'b0, 2'd0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;

      // Asynchronous reset mid-lockout.
      for (int r = 0; r < 3; r++) begin
         stepCheck($sformatf("t6_r%0d_d0", r), 1'b1, 2'd3, 4'b1110, 1'b0, 1'b0, 2'(r));
         stepCheck($sformatf("t6_r%0d_d1", r), 1'b1, 2'd3, 4'b1100, 1'b0, 1'b0, 2'(r));
         stepCheck($sformatf("t6_r%0d_d2", r), 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0, 2'(r));
         if (r < 2)
            stepCheck($sformatf("t6_r%0d_d3", r), 1'b1, 2'd3, 4'b1111, 1'b0, 1'b0, 2'(r + 1));
         else
            stepCheck("t6_r2_d3", 1'b1, 2'd3, 4'b0110, 1'b0, 1'b1, 2'd3);
      end
      stepCheck("t6_lock_a", 1'b0, 2'd0, 4'b0110, 1'b0, 1'b1, 2'd3);
      stepCheck("t6_lock_b", 1'b0, 2'd0, 4'b0110, 1'b0, 1'b1, 2'd3);
      #2;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_lockout", 4'b1111, 1'b0, 1'b0, 2'd0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      stepCheck("t6_post0", 1'b1, 2'd0, 4'b1110, 1'b0, 1'b0, 2'd0);
      stepCheck("t6_post1", 1'b1, 2'd0, 4'b1100, 1'b0, 1'b0, 2'd0);
      stepCheck("t6_post2", 1'b1, 2'd0, 4'b1000, 1'b0, 1'b0, 2'd0);
      stepCheck("t6_post3", 1'b1, 2'd0, 4'b1111, 1'b0, 1'b0, 2'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
